// File: rtl/alu_rs.sv
// Reservation station for the ALU pipe: buffers dispatched ops and snoops the CDB
// for missing operands. It issues one ready entry per cycle to the combinational ALU.
module alu_rs #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             disp_valid_i,
    output logic             disp_ready_o,
    input  logic [3:0]       disp_func_i,
    input  logic [WIDTH-1:0] disp_op1_i,
    input  logic [WIDTH-1:0] disp_op2_i,
    input  logic             disp_op1_rdy_i,
    input  logic             disp_op2_rdy_i,
    input  logic [TAG_W-1:0] disp_op1_tag_i,
    input  logic [TAG_W-1:0] disp_op2_tag_i,
    input  logic [TAG_W-1:0] disp_dest_tag_i,
    input  logic             cdb_valid_i,
    input  logic [TAG_W-1:0] cdb_tag_i,
    input  logic [WIDTH-1:0] cdb_data_i,
    output logic             issue_valid_o,
    input  logic             issue_ready_i,
    output logic [WIDTH-1:0] alu_op1_o,
    output logic [WIDTH-1:0] alu_op2_o,
    output logic [3:0]       alu_func_o,
    output logic [TAG_W-1:0] issue_tag_o
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] op1_rdy;
    logic [DEPTH-1:0] op2_rdy;
    logic [3:0]       func_q  [DEPTH];
    logic [TAG_W-1:0] dest_q  [DEPTH];
    logic [TAG_W-1:0] op1_tag [DEPTH];
    logic [TAG_W-1:0] op2_tag [DEPTH];
    logic [WIDTH-1:0] op1_val [DEPTH];
    logic [WIDTH-1:0] op2_val [DEPTH];

    logic             lock;
    logic [IDX_W-1:0] lock_idx;

    logic [DEPTH-1:0] cand;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic [IDX_W-1:0] free_idx;
    logic             free_found;
    logic             disp_fire;
    logic             issue_fire;
    logic             d_op1_rdy;
    logic             d_op2_rdy;
    logic [WIDTH-1:0] d_op1_val;
    logic [WIDTH-1:0] d_op2_val;

    always_comb begin
        cand       = busy & op1_rdy & op2_rdy;
        sel_idx    = '0;
        sel_found  = 1'b0;
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!sel_found && cand[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
            if (!free_found && !busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
        // A stalled issue keeps its entry pinned so the ALU inputs do not change under it.
        if (lock) begin
            sel_found = 1'b1;
            sel_idx   = lock_idx;
        end
    end

    assign disp_ready_o  = free_found;
    assign disp_fire     = disp_valid_i & free_found;
    assign issue_valid_o = sel_found;
    assign issue_fire    = sel_found & issue_ready_i;

    always_comb begin
        alu_op1_o   = '0;
        alu_op2_o   = '0;
        alu_func_o  = '0;
        issue_tag_o = '0;
        if (sel_found) begin
            alu_op1_o   = op1_val[sel_idx];
            alu_op2_o   = op2_val[sel_idx];
            alu_func_o  = func_q[sel_idx];
            issue_tag_o = dest_q[sel_idx];
        end
    end

    // Same-cycle CDB broadcast is captured at dispatch so the operand is not missed.
    always_comb begin
        d_op1_rdy = disp_op1_rdy_i | (cdb_valid_i && (cdb_tag_i == disp_op1_tag_i));
        d_op2_rdy = disp_op2_rdy_i | (cdb_valid_i && (cdb_tag_i == disp_op2_tag_i));
        d_op1_val = disp_op1_rdy_i ? disp_op1_i : cdb_data_i;
        d_op2_val = disp_op2_rdy_i ? disp_op2_i : cdb_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy     <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (flush_i) begin
            busy <= '0;
            lock <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (busy[i] && cdb_valid_i) begin
                    if (!op1_rdy[i] && (op1_tag[i] == cdb_tag_i)) begin
                        op1_rdy[i] <= 1'b1;
                        op1_val[i] <= cdb_data_i;
                    end
                    if (!op2_rdy[i] && (op2_tag[i] == cdb_tag_i)) begin
                        op2_rdy[i] <= 1'b1;
                        op2_val[i] <= cdb_data_i;
                    end
                end
            end
            if (issue_fire) begin
                busy[sel_idx] <= 1'b0;
            end
            if (disp_fire) begin
                busy[free_idx]    <= 1'b1;
                func_q[free_idx]  <= disp_func_i;
                dest_q[free_idx]  <= disp_dest_tag_i;
                op1_tag[free_idx] <= disp_op1_tag_i;
                op2_tag[free_idx] <= disp_op2_tag_i;
                op1_rdy[free_idx] <= d_op1_rdy;
                op2_rdy[free_idx] <= d_op2_rdy;
                op1_val[free_idx] <= d_op1_val;
                op2_val[free_idx] <= d_op2_val;
            end
            lock     <= sel_found & ~issue_ready_i;
            lock_idx <= sel_idx;
        end
    end
endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: stimulus pushes expected issues, a negedge monitor
// pops and compares them whenever an issue handshake completes.
module tb_alu_rs;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int TAG_W = 6;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    logic [3:0]       disp_func;
    logic [WIDTH-1:0] disp_op1, disp_op2;
    logic             disp_op1_rdy, disp_op2_rdy;
    logic [TAG_W-1:0] disp_op1_tag, disp_op2_tag, disp_dest_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [WIDTH-1:0] cdb_data;
    logic             issue_valid;
    logic             issue_ready;
    logic [WIDTH-1:0] alu_op1, alu_op2;
    logic [3:0]       alu_func;
    logic [TAG_W-1:0] issue_tag;

    alu_rs #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .disp_valid_i(disp_valid), .disp_ready_o(disp_ready), .disp_func_i(disp_func),
        .disp_op1_i(disp_op1), .disp_op2_i(disp_op2),
        .disp_op1_rdy_i(disp_op1_rdy), .disp_op2_rdy_i(disp_op2_rdy),
        .disp_op1_tag_i(disp_op1_tag), .disp_op2_tag_i(disp_op2_tag),
        .disp_dest_tag_i(disp_dest_tag),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
        .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
        .alu_op1_o(alu_op1), .alu_op2_o(alu_op2), .alu_func_o(alu_func),
        .issue_tag_o(issue_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] op1;
        logic [WIDTH-1:0] op2;
        logic [3:0]       func;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic disp(input logic [3:0] f,
                        input logic [WIDTH-1:0] a, input logic ar, input logic [TAG_W-1:0] at,
                        input logic [WIDTH-1:0] b, input logic br, input logic [TAG_W-1:0] bt,
                        input logic [TAG_W-1:0] d);
        disp_valid    = 1'b1;
        disp_func     = f;
        disp_op1      = a;
        disp_op1_rdy  = ar;
        disp_op1_tag  = at;
        disp_op2      = b;
        disp_op2_rdy  = br;
        disp_op2_tag  = bt;
        disp_dest_tag = d;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] v);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = v;
    endtask

    task automatic expect_issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic [3:0] f, input logic [TAG_W-1:0] t);
        exp_t e;
        e.op1  = a;
        e.op2  = b;
        e.func = f;
        e.tag  = t;
        exp_q.push_back(e);
    endtask

    // Monitor: inputs change at posedge+1, so negedge sees a stable handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !flush && issue_valid && issue_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected: got tag %0d op1 0x%0h op2 0x%0h, expected no issue",
                             issue_tag, alu_op1, alu_op2);
                end else begin
                    e = exp_q.pop_front();
                    if ({alu_op1, alu_op2, alu_func, issue_tag} !== e) begin
                        errors++;
                        $display("FAIL issue_tag%0d: got op1=0x%0h op2=0x%0h func=%0d tag=%0d, expected op1=0x%0h op2=0x%0h func=%0d tag=%0d",
                                 e.tag, alu_op1, alu_op2, alu_func, issue_tag, e.op1, e.op2, e.func, e.tag);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        issue_ready = 1'b0;
        idle();
        disp(OP_ADD, '0, 1'b0, '0, '0, 1'b0, '0, '0);
        disp_valid = 1'b0;
        cdb_tag  = '0;
        cdb_data = '0;
        cyc();
        cyc();
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_op1", alu_op1, 0);
        chk("rst_op2", alu_op2, 0);
        chk("rst_func", alu_func, 0);
        chk("rst_tag", issue_tag, 0);
        rst = 1'b0;

        // Both operands ready: issues the cycle after dispatch, then frees.
        issue_ready = 1'b1;
        disp(OP_ADD, 5, 1, 0, 7, 1, 0, 3);
        expect_issue(5, 7, OP_ADD, 3);
        cyc();
        idle();
        chk("add_valid", issue_valid, 1);
        chk("add_op1", alu_op1, 5);
        chk("add_op2", alu_op2, 7);
        chk("add_func", alu_func, OP_ADD);
        chk("add_tag", issue_tag, 3);
        cyc();
        chk("add_freed_valid", issue_valid, 0);
        chk("add_freed_ready", disp_ready, 1);

        // op2 waits on tag 9; CDB arrives two cycles later.
        disp(OP_SUB, 10, 1, 0, 0, 0, 9, 4);
        expect_issue(10, 32'h20, OP_SUB, 4);
        cyc();
        idle();
        chk("sub_wait1", issue_valid, 0);
        cyc();
        chk("sub_wait2", issue_valid, 0);
        cdb(9, 32'h20);
        cyc();
        idle();
        chk("sub_woken_valid", issue_valid, 1);
        chk("sub_woken_op2", alu_op2, 32'h20);
        cyc();
        chk("sub_done", issue_valid, 0);

        // CDB in the same cycle as dispatch is captured.
        disp(OP_AND, 0, 0, 12, 32'hFF, 1, 0, 5);
        cdb(12, 32'hF0F0);
        expect_issue(32'hF0F0, 32'hFF, OP_AND, 5);
        cyc();
        idle();
        chk("bypass_valid", issue_valid, 1);
        chk("bypass_op1", alu_op1, 32'hF0F0);
        cyc();
        chk("bypass_done", issue_valid, 0);

        // Fill the station, hold a fifth dispatch, then stall and wake entry 0.
        issue_ready = 1'b0;
        expect_issue(1, 2, OP_ADD, 11);
        expect_issue(3, 4, OP_ADD, 12);
        expect_issue(32'h100, 1, OP_OR, 10);
        expect_issue(9, 9, OP_ADD, 14);
        expect_issue(5, 6, OP_ADD, 13);
        disp(OP_OR, 0, 0, 20, 1, 1, 0, 10);
        cyc();
        disp(OP_ADD, 1, 1, 0, 2, 1, 0, 11);
        cyc();
        disp(OP_ADD, 3, 1, 0, 4, 1, 0, 12);
        cyc();
        disp(OP_ADD, 5, 1, 0, 6, 1, 0, 13);
        cyc();
        chk("full_ready", disp_ready, 0);
        disp(OP_ADD, 9, 1, 0, 9, 1, 0, 14);
        cyc();
        chk("full_hold_ready", disp_ready, 0);
        chk("lock_e1_tag", issue_tag, 11);
        issue_ready = 1'b1;
        cyc();
        chk("ready_after_issue", disp_ready, 1);
        chk("select_e2_tag", issue_tag, 12);
        issue_ready = 1'b0;
        cyc();
        disp_valid = 1'b0;
        chk("fifth_written_full", disp_ready, 0);
        chk("stall1_tag", issue_tag, 12);
        cdb(20, 32'h100);
        cyc();
        idle();
        chk("stall2_tag", issue_tag, 12);
        chk("stall2_op1", alu_op1, 3);
        cyc();
        chk("stall3_tag", issue_tag, 12);
        chk("stall3_op2", alu_op2, 4);
        chk("stall3_valid", issue_valid, 1);
        issue_ready = 1'b1;
        cyc();
        chk("e0_tag", issue_tag, 10);
        chk("e0_op1", alu_op1, 32'h100);
        chk("e0_func", alu_func, OP_OR);
        cyc();
        chk("fifth_tag", issue_tag, 14);
        cyc();
        chk("e3_tag", issue_tag, 13);
        cyc();
        chk("drained_valid", issue_valid, 0);

        // Flush with a lock held; nothing flushed may issue later.
        issue_ready = 1'b0;
        disp(OP_ADD, 32'h11, 1, 0, 32'h22, 1, 0, 20);
        cyc();
        disp(OP_SUB, 32'h33, 1, 0, 32'h44, 1, 0, 21);
        cyc();
        disp(OP_ADD, 0, 0, 30, 1, 1, 0, 22);
        cyc();
        chk("pre_flush_valid", issue_valid, 1);
        chk("pre_flush_tag", issue_tag, 20);
        flush = 1'b1;
        issue_ready = 1'b1;
        disp(OP_ADD, 1, 1, 0, 1, 1, 0, 23);
        cyc();
        idle();
        chk("flush_valid", issue_valid, 0);
        chk("flush_ready", disp_ready, 1);
        chk("flush_tag", issue_tag, 0);
        chk("flush_op1", alu_op1, 0);
        cdb(30, 5);
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("post_flush_valid", issue_valid, 0);
            cyc();
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
- Reservation station that buffers dispatched ALU instructions until both source operands are available.
- Snoops the common data bus (CDB) to capture results for pending operands.
- Issues one ready instruction per cycle into the combinational ALU, driving its op1/op2/func inputs.
- Sits between rename/dispatch and the ALU execute stage of the out-of-order core.

Parameters:
- WIDTH, 32, operand/data width.
- DEPTH, 4, number of station entries (power of two, ≥2).
- TAG_W, 6, ROB/physical tag width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- flush_i  input  1  squash: invalidate all entries.
- disp_valid_i  input  1  dispatch request.
- disp_ready_o  output  1  station can accept.
- disp_func_i  input  4  ALU function code (ALU_OP_* encoding).
- disp_op1_i / disp_op2_i  input  WIDTH each  operand value, meaningful when the matching rdy is high.
- disp_op1_rdy_i / disp_op2_rdy_i  input  1 each  operand already valid.
- disp_op1_tag_i / disp_op2_tag_i  input  TAG_W each  producer tag when not ready.
- disp_dest_tag_i  input  TAG_W  destination tag.
- cdb_valid_i  input  1  CDB broadcast valid.
- cdb_tag_i  input  TAG_W  broadcast tag.
- cdb_data_i  input  WIDTH  broadcast value.
- issue_valid_o  output  1  an entry is presented to the ALU.
- issue_ready_i  input  1  ALU/execute stage accepts.
- alu_op1_o / alu_op2_o  output  WIDTH each  operands to ALU.
- alu_func_o  output  4  function to ALU.
- issue_tag_o  output  TAG_W  destination tag of the issued instruction.

Behaviour:
- Entry state: busy, func, dest tag, and per operand {rdy, tag, value}.
- Reset (rst_i=1 at posedge):
  - All busy=0, lock=0.
  - Outputs: disp_ready_o=1, issue_valid_o=0, alu_op1_o/alu_op2_o/alu_func_o/issue_tag_o=0.
- Outputs are forced to 0 whenever issue_valid_o=0.

Dispatch:
- Fires when disp_valid_i & disp_ready_o.
- disp_ready_o = (busy count < DEPTH), computed from start-of-cycle state. A same-cycle issue does NOT free space for a same-cycle dispatch when full.
- New instruction is written into the lowest-index non-busy entry.
- Dispatch/CDB bypass: if a non-ready source tag equals cdb_tag_i with cdb_valid_i high in the dispatch cycle, that operand is written ready with cdb_data_i.

Wakeup:
- Each cycle, every busy entry compares each non-ready operand tag to cdb_tag_i when cdb_valid_i=1.
- On a match, the entry sets rdy and latches cdb_data_i. Both operands of one entry may wake in the same cycle.

Issue select:
- Combinational from registered entry state.
- Candidate = busy & op1 rdy & op2 rdy.
- An entry woken or dispatched in cycle t is first issuable in cycle t+1 (no same-cycle CDB-to-issue path).
- When unlocked, select the lowest-index candidate.
- Lock register holds the selected index: if issue_valid_o=1 and issue_ready_i=0, lock=1 and the same entry stays selected next cycle. Issue outputs stay stable until accepted.
- Lock clears on acceptance.

Issue fire:
- Fires when issue_valid_o & issue_ready_i; that entry's busy clears at the posedge.
- One issue per cycle maximum.

Flush:
- flush_i=1 at posedge: all busy=0 and lock=0. Dispatch and issue in that cycle are discarded.
- rst_i has priority over flush_i.

Full / empty:
- Full: disp_ready_o=0 and incoming dispatch is ignored.
- Empty: issue_valid_o=0.

Test Plan:
- Reset -> disp_ready_o=1, issue_valid_o=0, all ALU outputs 0.
- Dispatch ADD, op1=5 rdy, op2=7 rdy, dest=3, issue_ready_i=1 -> next cycle issue_valid_o=1, alu_op1_o=5, alu_op2_o=7, alu_func_o=ALU_OP_ADD, issue_tag_o=3; entry freed the following cycle.
- Dispatch SUB with op2 waiting on tag 9; CDB {9, 0x20} two cycles later -> issue_valid_o first asserts the cycle after the CDB, alu_op2_o=0x20.
- CDB {9, 0x20} in the same cycle as dispatch of an op waiting on tag 9 -> operand captured; issuable next cycle.
- Fill 4 entries (entry 0 operand not ready), disp_valid_i held high -> disp_ready_o=0 and the 5th instruction is not written; issuing entry 1 re-raises disp_ready_o only the cycle after the issue.
- issue_ready_i=0 for 3 cycles while entry 2 is selected and entry 0 wakes meanwhile -> outputs remain entry 2's values until accepted, then entry 0 issues.
- Entries busy plus lock held, flush_i=1 -> next cycle issue_valid_o=0, disp_ready_o=1, no later issue of flushed entries.
